axiwb_rw_arbiter: RTL



---
 rtl/axiwb_rw_arbiter_pkg.sv | 30 +++
 rtl/axiwb_rw_arbiter_if.sv | 53 +++++
 rtl/wbarb_counter.sv | 46 ++++
 rtl/axiwb_rw_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/axiwb_rw_arbiter_pkg.sv
// Shared definitions for the AXI-to-Wishbone read/write bus arbiter:
// FSM state encoding, owner constants and state-selection helpers.
package axiwb_rw_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StOwnRd,
        StOwnWr,
        StDrainRd,
        StDrainWr
    } arb_state_e;

    typedef enum logic {
        OwnerRd = 1'b0,
        OwnerWr = 1'b1
    } owner_e;

    function automatic arb_state_e own_state(input owner_e o);
        return (o == OwnerWr) ? StOwnWr : StOwnRd;
    endfunction

    function automatic arb_state_e drain_state(input owner_e o);
        return (o == OwnerWr) ? StDrainWr : StDrainRd;
    endfunction

    function automatic owner_e other_owner(input owner_e o);
        return (o == OwnerWr) ? OwnerRd : OwnerWr;
    endfunction

endpackage

// File: rtl/axiwb_rw_arbiter_if.sv
// Signal bundle between the two bridge masters, the arbiter and the shared Wishbone bus.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface axiwb_rw_arbiter_if #(
    parameter int unsigned AW = 26,
    parameter int unsigned DW = 32
);
    logic            i_rd_cyc;
    logic            i_rd_stb;
    logic [AW-1:0]   i_rd_addr;
    logic            o_rd_stall;
    logic            o_rd_ack;
    logic            o_rd_err;
    logic [DW-1:0]   o_rd_data;

    logic            i_wr_cyc;
    logic            i_wr_stb;
    logic [AW-1:0]   i_wr_addr;
    logic [DW-1:0]   i_wr_data;
    logic [DW/8-1:0] i_wr_sel;
    logic            o_wr_stall;
    logic            o_wr_ack;
    logic            o_wr_err;

    logic            o_wb_cyc;
    logic            o_wb_stb;
    logic            o_wb_we;
    logic [AW-1:0]   o_wb_addr;
    logic [DW-1:0]   o_wb_data;
    logic [DW/8-1:0] o_wb_sel;
    logic            i_wb_stall;
    logic            i_wb_ack;
    logic            i_wb_err;
    logic [DW-1:0]   i_wb_data;

    modport slave (
        input  i_rd_cyc, i_rd_stb, i_rd_addr,
        output o_rd_stall, o_rd_ack, o_rd_err, o_rd_data,
        input  i_wr_cyc, i_wr_stb, i_wr_addr, i_wr_data, i_wr_sel,
        output o_wr_stall, o_wr_ack, o_wr_err,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );

    modport master (
        output i_rd_cyc, i_rd_stb, i_rd_addr,
        input  o_rd_stall, o_rd_ack, o_rd_err, o_rd_data,
        output i_wr_cyc, i_wr_stb, i_wr_addr, i_wr_data, i_wr_sel,
        input  o_wr_stall, o_wr_ack, o_wr_err,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );

endinterface

// File: rtl/wbarb_counter.sv
// Up/down outstanding-request counter with synchronous clear, saturation and zero flags.
// A decrement at zero is ignored so stray acknowledgements cannot underflow it.
module wbarb_counter #(
    parameter int unsigned Width    = 6,
    parameter int unsigned MaxCount = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [Width-1:0] count_o,
    output logic             sat_o,
    output logic             zero_o
);

    localparam logic [Width-1:0] MaxVal = Width'(MaxCount);

    logic [Width-1:0] count_q, count_d;
    logic             dec_eff;

    assign zero_o  = (count_q == '0);
    assign sat_o   = (count_q == MaxVal);
    assign count_o = count_q;
    assign dec_eff = dec_i && !zero_o;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !dec_eff && !sat_o) begin
            count_d = count_q + Width'(1);
        end else if (!inc_i && dec_eff) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axiwb_rw_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone bus between the read and write bridge
// masters, with a per-tenure strobe limit and ownership handover only once acks have drained.
module axiwb_rw_arbiter
    import axiwb_rw_arbiter_pkg::*;
#(
    parameter int unsigned AW            = 26,
    parameter int unsigned DW            = 32,
    parameter int unsigned LGMAXBURST    = 4,
    parameter int unsigned LGOUTSTANDING = 5
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    axiwb_rw_arbiter_if.slave bus
);

    localparam int unsigned NoutW   = LGOUTSTANDING + 1;
    localparam int unsigned NburstW = LGMAXBURST + 1;
    localparam logic [NburstW-1:0] BurstMax = NburstW'(1 << LGMAXBURST);

    arb_state_e          state_q, state_d;
    owner_e              last_owner_q, last_owner_d;
    logic [NburstW-1:0]  nburst_q, nburst_d;

    logic [NoutW-1:0]    nout;
    logic                nout_max, nout_zero, nout_clr, nout_zero_next;

    logic                has_owner, own_wr, in_drain;
    owner_e              x_owner;
    logic                x_cyc, x_stb, other_cyc, burst_done, stb_acc;
    logic                x_stall, x_ack, x_err;
    logic                wb_stb;
    logic [AW-1:0]       x_addr;
    logic [DW-1:0]       x_data;
    logic [DW/8-1:0]     x_sel;

    // Decode who owns the bus and gather that master's request signals.
    always_comb begin
        has_owner  = (state_q != StIdle);
        own_wr     = (state_q == StOwnWr) || (state_q == StDrainWr);
        in_drain   = (state_q == StDrainRd) || (state_q == StDrainWr);
        x_owner    = own_wr ? OwnerWr : OwnerRd;
        x_cyc      = own_wr ? bus.i_wr_cyc : bus.i_rd_cyc;
        x_stb      = own_wr ? bus.i_wr_stb : bus.i_rd_stb;
        other_cyc  = own_wr ? bus.i_rd_cyc : bus.i_wr_cyc;
        burst_done = other_cyc && (nburst_q == BurstMax);
        x_addr     = own_wr ? bus.i_wr_addr : bus.i_rd_addr;
        x_data     = own_wr ? bus.i_wr_data : '0;
        x_sel      = own_wr ? bus.i_wr_sel : '1;
    end

    // Request/response routing; the burst limit blocks further strobes one cycle before DRAIN.
    always_comb begin
        wb_stb  = 1'b0;
        x_stall = 1'b1;
        x_ack   = 1'b0;
        x_err   = 1'b0;
        if (has_owner) begin
            x_ack = bus.i_wb_ack && x_cyc;
            x_err = bus.i_wb_err && x_cyc;
            if (!in_drain) begin
                wb_stb  = x_cyc && x_stb && !nout_max && !burst_done;
                x_stall = bus.i_wb_stall || nout_max || burst_done;
            end
        end
    end

    assign stb_acc        = wb_stb && !bus.i_wb_stall;
    assign nout_zero_next = nout_zero || ((nout == NoutW'(1)) && bus.i_wb_ack);

    assign bus.o_wb_cyc   = has_owner && x_cyc;
    assign bus.o_wb_stb   = wb_stb;
    assign bus.o_wb_we    = has_owner && own_wr;
    assign bus.o_wb_addr  = x_addr;
    assign bus.o_wb_data  = x_data;
    assign bus.o_wb_sel   = x_sel;
    assign bus.o_rd_data  = bus.i_wb_data;
    assign bus.o_rd_stall = own_wr ? 1'b1 : x_stall;
    assign bus.o_rd_ack   = !own_wr && x_ack;
    assign bus.o_rd_err   = !own_wr && x_err;
    assign bus.o_wr_stall = own_wr ? x_stall : 1'b1;
    assign bus.o_wr_ack   = own_wr && x_ack;
    assign bus.o_wr_err   = own_wr && x_err;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        nburst_d     = nburst_q;
        nout_clr     = 1'b0;
        if (stb_acc && (nburst_q != BurstMax)) begin
            nburst_d = nburst_q + NburstW'(1);
        end
        unique case (state_q)
            StIdle: begin
                nburst_d = '0;
                if (bus.i_rd_cyc && bus.i_wr_cyc) begin
                    state_d = own_state(other_owner(last_owner_q));
                end else if (bus.i_rd_cyc) begin
                    state_d = StOwnRd;
                end else if (bus.i_wr_cyc) begin
                    state_d = StOwnWr;
                end
            end
            StOwnRd, StOwnWr: begin
                if (!x_cyc) begin
                    state_d      = StIdle;
                    nout_clr     = 1'b1;
                    last_owner_d = x_owner;
                end else if (!bus.i_wb_err && burst_done) begin
                    state_d = drain_state(x_owner);
                end
            end
            StDrainRd, StDrainWr: begin
                if (!x_cyc) begin
                    state_d      = other_cyc ? own_state(other_owner(x_owner)) : StIdle;
                    nout_clr     = 1'b1;
                    nburst_d     = '0;
                    last_owner_d = x_owner;
                end else if (!bus.i_wb_err) begin
                    // A vanished competitor returns the tenure before any drained handover.
                    if (!other_cyc) begin
                        state_d  = own_state(x_owner);
                        nburst_d = '0;
                    end else if (nout_zero_next) begin
                        state_d      = own_state(other_owner(x_owner));
                        nburst_d     = '0;
                        last_owner_d = x_owner;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (has_owner && bus.i_wb_err) begin
            nout_clr = 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q      <= StIdle;
            last_owner_q <= OwnerWr;
            nburst_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            nburst_q     <= nburst_d;
        end
    end

    wbarb_counter #(
        .Width    (NoutW),
        .MaxCount (1 << LGOUTSTANDING)
    ) u_nout (
        .clk_i   (S_AXI_ACLK),
        .rst_ni  (S_AXI_ARESETN),
        .inc_i   (stb_acc),
        .dec_i   (has_owner && bus.i_wb_ack),
        .clr_i   (nout_clr),
        .count_o (nout),
        .sat_o   (nout_max),
        .zero_o  (nout_zero)
    );

endmodule
